// File: rtl/max7219_rx.sv
// max7219_rx: MAX7219 daisy-chain receiver (cs/sck/mosi) with per-device
// register file, registered read port and load/frame_err strobes.
// Ports: clk, reset (sync, active high); cs/sck/mosi async serial inputs;
//   rd_dev/rd_addr select a register, rd_data returns it one cycle later;
//   load / frame_err pulse on frame end; busy is high while a frame is armed.
// Optional: define MAX7219_RX_CODEB_EN to return Code-B segment patterns
//   for digit rows whose decode-mode bit is set.
module max7219_rx #(
   parameter int CHAIN = 4,
   parameter int DEV_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cs,
   input  logic             sck,
   input  logic             mosi,
   input  logic [DEV_W-1:0] rd_dev,
   input  logic [3:0]       rd_addr,
   output logic [7:0]       rd_data,
   output logic             load,
   output logic             frame_err,
   output logic             busy
);

   localparam int         SR_W = 16 * CHAIN;
   localparam logic [7:0] FULL = 8'(SR_W);

   // Synchronisers; the third cs/sck stage is the edge-detect history.
   logic [2:0] cs_sync_q, cs_sync_d;
   logic [2:0] sck_sync_q, sck_sync_d;
   logic [1:0] mosi_sync_q, mosi_sync_d;

   logic            armed_q, armed_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [SR_W-1:0] sr_q, sr_d;
   logic            load_q, load_d;
   logic            err_q, err_d;
   logic [7:0]      rd_q, rd_d;

   logic [7:0] digit_q  [CHAIN][8];
   logic [7:0] digit_d  [CHAIN][8];
   logic [7:0] decode_q [CHAIN];
   logic [7:0] decode_d [CHAIN];
   logic [3:0] inten_q  [CHAIN];
   logic [3:0] inten_d  [CHAIN];
   logic [2:0] scan_q   [CHAIN];
   logic [2:0] scan_d   [CHAIN];
   logic       shdn_q   [CHAIN];
   logic       shdn_d   [CHAIN];
   logic       test_q   [CHAIN];
   logic       test_d   [CHAIN];

   logic cs_rise, cs_fall, sck_rise, mosi_s;

   assign cs_sync_d   = {cs_sync_q[1:0], cs};
   assign sck_sync_d  = {sck_sync_q[1:0], sck};
   assign mosi_sync_d = {mosi_sync_q[0], mosi};

   assign cs_rise  =  cs_sync_q[1] & ~cs_sync_q[2];
   assign cs_fall  = ~cs_sync_q[1] &  cs_sync_q[2];
   assign sck_rise =  sck_sync_q[1] & ~sck_sync_q[2];
   assign mosi_s   =  mosi_sync_q[1];

`ifdef MAX7219_RX_CODEB_EN
   function automatic logic [7:0] codeb(input logic [7:0] v);
      logic [6:0] s;
      case (v[3:0])
         4'h0: s = 7'h7E;
         4'h1: s = 7'h30;
         4'h2: s = 7'h6D;
         4'h3: s = 7'h79;
         4'h4: s = 7'h33;
         4'h5: s = 7'h5B;
         4'h6: s = 7'h5F;
         4'h7: s = 7'h70;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h7B;
         4'hA: s = 7'h01;
         4'hB: s = 7'h4F;
         4'hC: s = 7'h37;
         4'hD: s = 7'h0E;
         4'hE: s = 7'h67;
         default: s = 7'h00;
      endcase
      return {v[7], s};
   endfunction
`endif

   // Receive, count and commit.
   always_comb begin
      logic [3:0] wa;
      logic [7:0] wd;
      wa       = '0;
      wd       = '0;
      armed_d  = armed_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      load_d   = 1'b0;
      err_d    = 1'b0;
      digit_d  = digit_q;
      decode_d = decode_q;
      inten_d  = inten_q;
      scan_d   = scan_q;
      shdn_d   = shdn_q;
      test_d   = test_q;

      // Shift before commit so a coincident last sck edge is counted.
      if (armed_q && sck_rise) begin
         sr_d = {sr_q[SR_W-2:0], mosi_s};
         if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end

      if (cs_fall) begin
         armed_d = 1'b1;
         cnt_d   = '0;
      end else if (armed_q && cs_rise) begin
         armed_d = 1'b0;
         if (cnt_d == FULL) begin
            load_d = 1'b1;
            for (int k = 0; k < CHAIN; k++) begin
               wa = sr_d[16*k+8 +: 4];
               wd = sr_d[16*k +: 8];
               case (wa)
                  4'h1, 4'h2, 4'h3, 4'h4,
                  4'h5, 4'h6, 4'h7, 4'h8:
                     digit_d[k][3'(wa[2:0] - 3'd1)] = wd;
                  4'h9: decode_d[k] = wd;
                  4'hA: inten_d[k]  = wd[3:0];
                  4'hB: scan_d[k]   = wd[2:0];
                  4'hC: shdn_d[k]   = wd[0];
                  4'hF: test_d[k]   = wd[0];
                  default: ;
               endcase
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // Read mux works on pre-commit state.
   always_comb begin
      rd_d = '0;
      for (int k = 0; k < CHAIN; k++) begin
         if (rd_dev == DEV_W'(k)) begin
            case (rd_addr)
               4'h1, 4'h2, 4'h3, 4'h4,
               4'h5, 4'h6, 4'h7, 4'h8: begin
                  rd_d = digit_q[k][3'(rd_addr[2:0] - 3'd1)];
`ifdef MAX7219_RX_CODEB_EN
                  if (decode_q[k][3'(rd_addr[2:0] - 3'd1)])
                     rd_d = codeb(rd_d);
`endif
               end
               4'h9: rd_d = decode_q[k];
               4'hA: rd_d = {4'h0, inten_q[k]};
               4'hB: rd_d = {5'h00, scan_q[k]};
               4'hC: rd_d = {7'h00, shdn_q[k]};
               4'hF: rd_d = {7'h00, test_q[k]};
               default: rd_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // cs history clears low so a cs held low at release never arms.
         cs_sync_q   <= '0;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         armed_q     <= 1'b0;
         cnt_q       <= '0;
         sr_q        <= '0;
         load_q      <= 1'b0;
         err_q       <= 1'b0;
         rd_q        <= '0;
         for (int k = 0; k < CHAIN; k++) begin
            for (int r = 0; r < 8; r++) digit_q[k][r] <= '0;
            decode_q[k] <= '0;
            inten_q[k]  <= '0;
            scan_q[k]   <= '0;
            shdn_q[k]   <= 1'b0;
            test_q[k]   <= 1'b0;
         end
      end else begin
         cs_sync_q   <= cs_sync_d;
         sck_sync_q  <= sck_sync_d;
         mosi_sync_q <= mosi_sync_d;
         armed_q     <= armed_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         load_q      <= load_d;
         err_q       <= err_d;
         rd_q        <= rd_d;
         digit_q     <= digit_d;
         decode_q    <= decode_d;
         inten_q     <= inten_d;
         scan_q      <= scan_d;
         shdn_q      <= shdn_d;
         test_q      <= test_d;
      end
   end

   assign rd_data   = rd_q;
   assign load      = load_q;
   assign frame_err = err_q;
   assign busy      = armed_q;

endmodule

// File: tb/tb_max7219_rx.sv
// tb_max7219_rx: scoreboard bench for max7219_rx (CHAIN=4).
// Strobe expectations are queued per frame; reads use a reference model.
module tb_max7219_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       cs, sck, mosi;
   logic [1:0] rd_dev;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       load, frame_err, busy;

   int checks = 0;
   int errors = 0;

   logic [1:0] sb [$];          // 1 = load expected, 2 = frame_err expected
   logic [7:0] mdl [4][16];
   logic [6:0] cb [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
                           7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h01, 7'h4F,
                           7'h37, 7'h0E, 7'h67, 7'h00};

   max7219_rx #(.CHAIN(4), .DEV_W(2)) dut (
      .clk(clk), .reset(reset), .cs(cs), .sck(sck), .mosi(mosi),
      .rd_dev(rd_dev), .rd_addr(rd_addr), .rd_data(rd_data),
      .load(load), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Strobe monitor pops the scoreboard.
   always @(negedge clk) begin
      if (load || frame_err) begin
         if (sb.size() == 0) check("unexpected_strobe", {frame_err, load}, 0);
         else check("strobe", {frame_err, load}, sb.pop_front());
      end
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic mdl_clear();
      for (int d = 0; d < 4; d++)
         for (int a = 0; a < 16; a++) mdl[d][a] = 8'h00;
   endtask

   task automatic mdl_apply(input logic [127:0] f);
      logic [15:0] w;
      for (int d = 0; d < 4; d++) begin
         w = f[16*d +: 16];
         case (w[11:8])
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9:
               mdl[d][w[11:8]] = w[7:0];
            4'hA: mdl[d][10] = w[7:0] & 8'h0F;
            4'hB: mdl[d][11] = w[7:0] & 8'h07;
            4'hC: mdl[d][12] = w[7:0] & 8'h01;
            4'hF: mdl[d][15] = w[7:0] & 8'h01;
            default: ;
         endcase
      end
   endtask

   function automatic logic [7:0] exp_rd(input int d, input int a);
      logic [7:0] v;
      v = mdl[d][a];
`ifdef MAX7219_RX_CODEB_EN
      if (a >= 1 && a <= 8 && mdl[d][9][a-1]) v = {v[7], cb[v[3:0]]};
`endif
      return v;
   endfunction

   task automatic rd_chk(input string tag, input int d, input int a);
      rd_dev  = 2'(d);
      rd_addr = 4'(a);
      @(posedge clk);
      #1;
      check(tag, rd_data, exp_rd(d, a));
   endtask

   task automatic sbit(input logic b);
      mosi = b;
      sck  = 1'b0;
      clks(4);
      sck  = 1'b1;
      clks(4);
   endtask

   // Send n bits of f MSB first; coin raises cs together with the last sck.
   task automatic send(input logic [127:0] f, input int n, input bit coin);
      cs = 1'b0;
      clks(4);
      for (int i = n - 1; i >= 0; i--) begin
         if (coin && i == 0) begin
            mosi = f[0];
            sck  = 1'b0;
            clks(4);
            if (n == 64) begin
               sb.push_back(2'd1);
               mdl_apply(f);
            end else sb.push_back(2'd2);
            sck = 1'b1;
            cs  = 1'b1;
            clks(4);
         end else begin
            sbit(f[i]);
         end
         if (i == n / 2) check("busy_mid", busy, 1);
      end
      sck = 1'b0;
      if (!coin) begin
         clks(4);
         if (n == 64) begin
            sb.push_back(2'd1);
            mdl_apply(f);
         end else sb.push_back(2'd2);
         cs = 1'b1;
      end
      for (int i = 0; i < 12 && sb.size() != 0; i++) clks(1);
      check("strobe_drain", sb.size(), 0);
      clks(4);
      check("busy_idle", busy, 0);
   endtask

   initial begin
      logic [127:0] f;
      reset = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
      rd_dev = 2'd0; rd_addr = 4'd0;
      mdl_clear();
      clks(4);
      check("rst_rd_data", rd_data, 0);
      check("rst_load", load, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      clks(4);
      rd_chk("rst_shdn", 0, 12);

      // Valid frame, device 0 last.
      f = '0;
      f[63:0] = {16'h0000, 16'h0000, 16'h0000, 16'h0155};
      send(f, 64, 1'b0);
      rd_chk("t1_d0_a1", 0, 1);
      check("t1_d0_a1_const", rd_data, 8'h55);
      rd_chk("t1_d1_a1", 1, 1);

      // Short frame: error, no writes.
      f = '0;
      f[47:0] = {16'h0000, 16'h0000, 16'h0A3F};
      send(f, 48, 1'b0);
      for (int d = 0; d < 4; d++) rd_chk("t2_inten", d, 10);

      // Devices 2 and 3 written.
      f = '0;
      f[63:0] = {16'h0C01, 16'h0A3F, 16'h0000, 16'h0000};
      send(f, 64, 1'b0);
      rd_chk("t3_d2_inten", 2, 10);
      check("t3_d2_inten_const", rd_data, 8'h0F);
      rd_chk("t3_d3_shdn", 3, 12);
      check("t3_d3_shdn_const", rd_data, 8'h01);
      for (int d = 0; d < 4; d++)
         for (int a = 0; a < 16; a++) rd_chk("t3_all", d, a);

      // Reset mid-frame after 20 bits.
      cs = 1'b0;
      clks(4);
      for (int i = 0; i < 20; i++) sbit(1'($urandom_range(0, 1)));
      reset = 1'b1;
      clks(3);
      cs = 1'b1;
      sck = 1'b0;
      clks(2);
      reset = 1'b0;
      mdl_clear();
      clks(1);
      check("t4_busy_after_rst", busy, 0);
      clks(10);
      rd_chk("t4_cleared", 0, 1);
      f = '0;
      f[63:0] = {16'h0504, 16'h0403, 16'h0302, 16'h0201};
      send(f, 64, 1'b0);
      for (int d = 0; d < 4; d++) rd_chk("t4_digit", d, d + 2);

      // Last sck coincident with cs rise.
      f = '0;
      f[63:0] = {16'h0F01, 16'h0B05, 16'h0911, 16'h08AA};
      send(f, 64, 1'b1);
      rd_chk("t5_d0_a8", 0, 8);
      rd_chk("t5_d1_a9", 1, 9);
      rd_chk("t5_d2_scan", 2, 11);
      rd_chk("t5_d3_test", 3, 15);
      rd_chk("t5_d1_a3", 1, 3);

      // Code-B decode on device 0 row 0.
      f = '0;
      f[63:0] = {16'h0000, 16'h0000, 16'h0000, 16'h09FF};
      send(f, 64, 1'b0);
      f[15:0] = 16'h0105;
      send(f, 64, 1'b0);
      rd_chk("t6_d0_a1", 0, 1);
`ifdef MAX7219_RX_CODEB_EN
      check("t6_codeb5", rd_data, 8'h5B);
      f[15:0] = 16'h018E;
      send(f, 64, 1'b0);
      rd_chk("t6_d0_a1_dp", 0, 1);
      check("t6_codeb_e_dp", rd_data, 8'hE7);
`else
      check("t6_raw5", rd_data, 8'h05);
`endif

      clks(10);
      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
